// File: rtl/barcode_rx.sv
// barcode_rx: decodes the station barcode reader's serial stream into an
// 8-bit station ID. A start pulse's low width sets the bit period, and
// 8 data bits follow, MSB first. Only IDs with ID[7:6]==2'b00 are accepted.
// Optional feature macro: BC_TIMEOUT_EN adds an inter-bit timeout in
// WAIT_FALL of TO_MULT x period cycles.
module barcode_rx #(
    parameter int unsigned CNT_W   = 22,
    parameter int unsigned TO_MULT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld,
    output logic       busy
);

    localparam int unsigned BIT_W = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MEASURE   = 3'd1,
        WAIT_FALL = 3'd2,
        SAMPLE    = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               bc_meta;
    logic               bc_s;
    logic               bc_prev;
    logic               fall;
    logic               rise;

    logic [CNT_W-1:0]   period_cnt;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   smp_tmr;
    logic [CNT_W-1:0]   tmr_nxt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [7:0]         shift;

    logic               cnt_clr;
    logic               cnt_inc;
    logic               period_ld;
    logic               tmr_clr;
    logic               tmr_inc;
    logic               smp_en;
    logic               accept;
    logic               to_abort;

    // Edge detection on the synchronized line.
    assign fall    = bc_prev & ~bc_s;
    assign rise    = ~bc_prev & bc_s;
    assign tmr_nxt = smp_tmr + CNT_W'(1);

`ifdef BC_TIMEOUT_EN
    localparam int unsigned TO_W = CNT_W + $clog2(TO_MULT + 1);

    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_limit;

    assign to_limit = TO_W'(period) * TO_W'(TO_MULT);
    assign to_abort = (state == WAIT_FALL) && (to_cnt >= to_limit);

    // Timeout counter runs only while waiting for the next bit's falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == WAIT_FALL) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign to_abort = 1'b0;

    // TO_MULT only matters when the timeout is built in.
    if (TO_MULT > 0) begin : g_no_timeout
    end
`endif

    // Two-flop synchronizer plus a history flop for edge detection; idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_meta <= 1'b1;
            bc_s    <= 1'b1;
            bc_prev <= 1'b1;
        end else begin
            bc_meta <= BC;
            bc_s    <= bc_meta;
            bc_prev <= bc_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes; edges with no meaning in a state are ignored.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        period_ld = 1'b0;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        smp_en    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    cnt_clr   = 1'b1;
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_ld = 1'b1;
                    state_nxt = WAIT_FALL;
                end else if (period_cnt == '1) begin
                    state_nxt = IDLE;
                end else if (!bc_s) begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_FALL: begin
                if (fall) begin
                    tmr_clr   = 1'b1;
                    state_nxt = SAMPLE;
                end else if (to_abort) begin
                    state_nxt = IDLE;
                end
            end
            SAMPLE: begin
                tmr_inc = 1'b1;
                // >= keeps degenerate (sub-minimum) periods from stalling here.
                if (tmr_nxt >= period) begin
                    smp_en    = 1'b1;
                    state_nxt = (bit_cnt == BIT_W'(7)) ? DONE : WAIT_FALL;
                end
            end
            DONE: begin
                accept    = (shift[7:6] == 2'b00);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Period measurement, sample timer, bit counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            period     <= '0;
            smp_tmr    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
        end else begin
            if (cnt_clr) begin
                period_cnt <= '0;
            end else if (cnt_inc) begin
                period_cnt <= period_cnt + CNT_W'(1);
            end
            if (period_ld) begin
                period <= period_cnt;
            end
            if (period_ld) begin
                bit_cnt <= '0;
            end else if (smp_en) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (tmr_clr) begin
                smp_tmr <= '0;
            end else if (tmr_inc) begin
                smp_tmr <= tmr_nxt;
            end
            if (smp_en) begin
                shift <= {shift[6:0], bc_s};
            end
        end
    end

    // Registered outputs; a new accepted ID wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID     <= 8'h00;
            ID_vld <= 1'b0;
            busy   <= 1'b0;
        end else begin
            if (accept) begin
                ID     <= shift;
                ID_vld <= 1'b1;
            end else if (clr_ID_vld) begin
                ID_vld <= 1'b0;
            end
            busy <= (state_nxt != IDLE);
        end
    end

endmodule
